// File: rtl/button_debounce_pulse.sv
// button_debounce_pulse: synchronises a raw push-button, rejects bounce and emits
// one-cycle press/release strobes. Optional auto-repeat via the AUTO_REPEAT_EN macro.
`default_nettype none

module button_debounce_pulse #(
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 2047,
    parameter int REPEAT_DELAY    = 8000,
    parameter int REPEAT_PERIOD   = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic button_level,
    output logic button_pulse,
    output logic release_pulse,
    output logic repeat_active
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_debounce_pulse: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        ARM_RELEASE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   rel_q, rel_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W  = $clog2(RPT_MAX + 1);
    localparam logic [RCNT_W-1:0] RCNT_ONE    = RCNT_W'(1);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              ract_q, ract_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            rel_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rcnt_q  <= '0;
            ract_q  <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], button_raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            rel_q   <= rel_d;
`ifdef AUTO_REPEAT_EN
            rcnt_q  <= rcnt_d;
            ract_q  <= ract_d;
`endif
        end
    end

    // Counters default to zero so every state entry starts from a clean count.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        level_d = level_q;
        pulse_d = 1'b0;
        rel_d   = 1'b0;
`ifdef AUTO_REPEAT_EN
        rcnt_d  = '0;
        ract_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = ARM_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            ARM_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = ARM_RELEASE;
                    cnt_d   = CNT_ONE;
                end
`ifdef AUTO_REPEAT_EN
                else if (rcnt_q == (ract_q ? PERIOD_LAST : DELAY_LAST)) begin
                    pulse_d = 1'b1;
                    ract_d  = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + RCNT_ONE;
                    ract_d = ract_q;
                end
`endif
            end
            ARM_RELEASE: begin
                if (s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign button_level  = level_q;
    assign button_pulse  = pulse_q;
    assign release_pulse = rel_q;
`ifdef AUTO_REPEAT_EN
    assign repeat_active = ract_q;
`else
    assign repeat_active = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_debounce_pulse.sv
// Testbench for button_debounce_pulse (SYNC_STAGES=3, DEBOUNCE_CYCLES=8, REPEAT 20/5).
`default_nettype none

module tb_button_debounce_pulse;

    localparam int SYNC = 3;
    localparam int DEB  = 8;
    localparam int RD   = 20;
    localparam int RP   = 5;
    localparam int LAT  = SYNC + DEB;

    logic clk = 1'b0;
    logic reset;
    logic button_raw;
    logic button_level, button_pulse, release_pulse, repeat_active;

    always #5 clk = ~clk;

    button_debounce_pulse #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_raw   (button_raw),
        .button_level (button_level),
        .button_pulse (button_pulse),
        .release_pulse(release_pulse),
        .repeat_active(repeat_active)
    );

    // exp = {level, pulse, release, repeat_active}
    typedef struct {
        string      tag;
        logic       rst_n;
        logic       raw;
        logic [3:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] sb[$];
    int         total = 0;
    int         bad   = 0;

    task automatic seg(input string tag, input logic r, input logic raw, input int n,
                       input logic l, input logic p, input logic rl, input logic ra);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v.tag = tag; v.rst_n = r; v.raw = raw; v.exp = {l, p, rl, ra};
            vecs.push_back(v);
        end
    endtask

    // press accepted after LAT samples of 1, then 'hold' more samples held high
    task automatic press(input string tag, input int hold);
        seg(tag, 1'b1, 1'b1, LAT - 1, 1'b0, 1'b0, 1'b0, 1'b0);
        seg(tag, 1'b1, 1'b1, 1,       1'b1, 1'b1, 1'b0, 1'b0);
        seg(tag, 1'b1, 1'b1, hold,    1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic release_seq(input string tag);
        seg(tag, 1'b1, 1'b0, LAT - 1, 1'b1, 1'b0, 1'b0, 1'b0);
        seg(tag, 1'b1, 1'b0, 1,       1'b0, 1'b0, 1'b1, 1'b0);
        seg(tag, 1'b1, 1'b0, 3,       1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply(input vec_t v);
        logic [3:0] got, exp;
        reset      = v.rst_n;
        button_raw = v.raw;
        sb.push_back(v.exp);
        @(posedge clk);
        @(negedge clk);
        got = {button_level, button_pulse, release_pulse, repeat_active};
        exp = sb.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got lvl/pls/rel/rpt=%b required=%b", v.tag, $time, got, exp);
        end
    endtask

    initial begin
        reset      = 1'b0;
        button_raw = 1'b0;

        seg("reset", 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0);

        press("press_latency", 6);
        release_seq("release_latency");

        for (int i = 0; i < 40; i++)
            seg("bounce_toggle", 1'b1, ((i / 3) % 2) == 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        seg("bounce_settle", 1'b1, 1'b0, 12, 1'b0, 1'b0, 1'b0, 1'b0);

        seg("glitch_one_short", 1'b1, 1'b1, DEB - 1, 1'b0, 1'b0, 1'b0, 1'b0);
        seg("glitch_one_short", 1'b1, 1'b0, 8,       1'b0, 1'b0, 1'b0, 1'b0);

        press("press_then_dip", 4);
        seg("release_dip", 1'b1, 1'b0, 5,  1'b1, 1'b0, 1'b0, 1'b0);
        seg("release_dip", 1'b1, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b0);
        release_seq("release_after_dip");

        seg("reset_midcount", 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        seg("reset_midcount", 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        press("press_after_reset", 3);
        release_seq("release_after_reset");

        press("hold_press", 0);
`ifdef AUTO_REPEAT_EN
        for (int j = 1; j <= 60; j++)
            seg("auto_repeat", 1'b1, 1'b1, 1, 1'b1,
                (j >= RD) && (((j - RD) % RP) == 0), 1'b0, j >= RD);
        for (int j = 1; j <= LAT + 3; j++)
            seg("repeat_release", 1'b1, 1'b0, 1, j < LAT, 1'b0, j == LAT, j <= SYNC);
`else
        seg("hold_no_repeat", 1'b1, 1'b1, 60, 1'b1, 1'b0, 1'b0, 1'b0);
        release_seq("hold_release");
`endif

        @(negedge clk);
        foreach (vecs[i]) apply(vecs[i]);

        // Asynchronous reset while pressed: outputs must clear without a clock edge.
        vecs.delete();
        press("press_before_async", 2);
        foreach (vecs[i]) apply(vecs[i]);
        #1 reset = 1'b0;
        #1;
        total++;
        if ({button_level, button_pulse, release_pulse, repeat_active} !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset: got=%b required=0000",
                     {button_level, button_pulse, release_pulse, repeat_active});
        end
        vecs.delete();
        seg("after_async", 1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        foreach (vecs[i]) apply(vecs[i]);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got=%0d entries required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
